// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC constants, arctangent table and FSM state encoding
package cordic_pkg;
  localparam logic [31:0] ANG_90 = 32'h4000_0000;
  localparam logic [15:0] K_GAIN = 16'd9949;
  localparam logic [31:0] ATAN_TAB [16] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861
  };
  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_SCALE} state_e;
endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring micro-rotation, reused every cycle
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int IW = 20
) (
  input  logic signed [IW-1:0] x_i,
  input  logic signed [IW-1:0] y_i,
  input  logic        [31:0]   z_i,
  input  logic        [3:0]    i_i,
  output logic signed [IW-1:0] x_o,
  output logic signed [IW-1:0] y_o,
  output logic        [31:0]   z_o
);
  logic signed [IW-1:0] xs, ys;
  logic [31:0] a;
  logic neg, hold;
  // Steer y toward zero; the all-zero vector is left alone so its angle stays at 0
  always_comb begin
    xs = x_i >>> i_i;
    ys = y_i >>> i_i;
    a = ATAN_TAB[i_i];
    neg = y_i[IW-1];
    hold = (x_i == '0) && (y_i == '0);
    x_o = hold ? x_i : (neg ? x_i - ys : x_i + ys);
    y_o = hold ? y_i : (neg ? y_i + xs : y_i - xs);
    z_o = hold ? z_i : (neg ? z_i - a : z_i + a);
  end
endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative CORDIC vectoring unit producing atan2(y,x) and gain-compensated magnitude
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int ITER = 16,
  parameter int IW   = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  output logic               busy,
  output logic               done,
  output logic        [31:0] angle_out,
  output logic        [15:0] mag_out
);
  state_e state_q, state_d;
  logic [3:0] i_q, i_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d, xe, ye, xs, ys;
  logic [31:0] z_q, z_d, zs;
  logic busy_q, busy_d, done_q, done_d;
  logic [31:0] angle_q, angle_d;
  logic [15:0] mag_q, mag_d, mag_sat;
  logic [IW+15:0] prod;
  logic [IW+1:0] scaled;

  cordic_vec_stage #(.IW(IW)) u_stage (
    .x_i(x_q),
    .y_i(y_q),
    .z_i(z_q),
    .i_i(i_q),
    .x_o(xs),
    .y_o(ys),
    .z_o(zs)
  );

  // Widen inputs for pre-rotation and gain-compensate x, clamping into the unsigned 16-bit range
  always_comb begin
    xe = {{(IW-16){x_in[15]}}, x_in};
    ye = {{(IW-16){y_in[15]}}, y_in};
    prod = {{16{x_q[IW-1]}}, x_q} * {{IW{1'b0}}, K_GAIN};
    scaled = (IW+2)'(prod >> 14);
    mag_sat = scaled[IW+1] ? 16'h0000 : (|scaled[IW:16] ? 16'hFFFF : scaled[15:0]);
  end

  // Next-state logic: accept and pre-rotate in IDLE, one micro-rotation per ITER cycle, publish in SCALE
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    busy_d = busy_q;
    done_d = 1'b0;
    angle_d = angle_q;
    mag_d = mag_q;
    if (state_q == ST_IDLE && start) begin
      state_d = ST_ITER;
      i_d = '0;
      busy_d = 1'b1;
      x_d = !x_in[15] ? xe : (y_in[15] ? -ye : ye);
      y_d = !x_in[15] ? ye : (y_in[15] ? xe : -xe);
      z_d = !x_in[15] ? '0 : (y_in[15] ? -ANG_90 : ANG_90);
    end else if (state_q == ST_ITER) begin
      x_d = xs;
      y_d = ys;
      z_d = zs;
      i_d = i_q + 4'd1;
      state_d = (i_q == 4'(ITER-1)) ? ST_SCALE : ST_ITER;
    end else if (state_q == ST_SCALE) begin
      angle_d = z_q;
      mag_d = mag_sat;
      done_d = 1'b1;
      busy_d = 1'b0;
      state_d = ST_IDLE;
    end
  end

  // State and datapath registers, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      i_q <= '0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      angle_q <= '0;
      mag_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      busy_q <= busy_d;
      done_q <= done_d;
      angle_q <= angle_d;
      mag_q <= mag_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign angle_out = angle_q;
  assign mag_out = mag_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: directed table, corner sequences and random vectors against a reference model
module tb_cordic_vectoring;
  localparam int ITER_N = 16;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset, start, busy, done;
  logic signed [15:0] x_in, y_in;
  logic [31:0] angle_out;
  logic [15:0] mag_out;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic signed [15:0] x, y;
    logic [31:0] ang;
    logic [15:0] mag;
    longint atol, mtol;
  } vec_t;

  cordic_vectoring #(.ITER(ITER_N), .IW(20)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .x_in(x_in),
    .y_in(y_in),
    .busy(busy),
    .done(done),
    .angle_out(angle_out),
    .mag_out(mag_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
    n_vec++;
    if (act - exp > tol || exp - act > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  task automatic chk_ang(input string nm, input logic [31:0] act, input logic [31:0] exp, input longint tol);
    longint d;
    d = longint'(int'(act - exp));
    n_vec++;
    if (d > tol || -d > tol) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (tol %0d)", nm, act, exp, tol);
    end
  endtask

  // Bit-accurate reference: quadrant fold, ITER_N vectoring steps, gain scaling with clamp
  function automatic void model(input logic signed [15:0] xi, input logic signed [15:0] yi,
                                output logic [31:0] ang, output logic [15:0] mg);
    longint x, y, t, p;
    int a;
    logic [31:0] z;
    if (xi >= 0) begin
      x = xi; y = yi; z = 32'h0;
    end else if (yi >= 0) begin
      x = yi; y = -longint'(xi); z = 32'h4000_0000;
    end else begin
      x = -longint'(yi); y = xi; z = 32'hC000_0000;
    end
    for (int i = 0; i < ITER_N; i++) begin
      if (x != 0 || y != 0) begin
        t = x;
        a = $rtoi($floor($atan(2.0 ** (-i)) * (2.0 ** 31) / PI + 0.5));
        if (y < 0) begin
          x = x - (y >>> i); y = y + (t >>> i); z = z - 32'(a);
        end else begin
          x = x + (y >>> i); y = y - (t >>> i); z = z + 32'(a);
        end
      end
    end
    p = (x * 9949) >>> 14;
    ang = z;
    mg = (p < 0) ? 16'h0 : (p > 65535) ? 16'hFFFF : 16'(p);
  endfunction

  task automatic run_op(input logic signed [15:0] x, input logic signed [15:0] y,
                        output logic [31:0] ang, output logic [15:0] mg, output int lat);
    @(negedge clk);
    x_in = x; y_in = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    ang = angle_out;
    mg = mag_out;
  endtask

  initial begin
    vec_t tab[6];
    logic [31:0] ang, eang, ang2, eang2;
    logic [15:0] mg, emag, mg2, emag2;
    int lat, nd, first, second;
    tab[0] = '{x: 16'sd16384,  y: 16'sd0,      ang: 32'h0000_0000, mag: 16'd16384, atol: 65536, mtol: 4};
    tab[1] = '{x: 16'sd0,      y: 16'sd16384,  ang: 32'h4000_0000, mag: 16'd16384, atol: 65536, mtol: 4};
    tab[2] = '{x: 16'sd11585,  y: 16'sd11585,  ang: 32'h2000_0000, mag: 16'd16384, atol: 65536, mtol: 4};
    tab[3] = '{x: -16'sd16384, y: -16'sd16384, ang: 32'hA000_0000, mag: 16'd23170, atol: 65536, mtol: 4};
    tab[4] = '{x: -16'sd16384, y: 16'sd0,      ang: 32'h8000_0000, mag: 16'd16384, atol: 65536, mtol: 4};
    tab[5] = '{x: 16'sd0,      y: 16'sd0,      ang: 32'h0000_0000, mag: 16'd0,     atol: 65536, mtol: 0};

    reset = 1'b0; start = 1'b0; x_in = '0; y_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0, 0);
    chk("reset_done", done, 0, 0);
    chk("reset_angle", angle_out, 0, 0);
    chk("reset_mag", mag_out, 0, 0);
    reset = 1'b1;

    for (int k = 0; k < 6; k++) begin
      run_op(tab[k].x, tab[k].y, ang, mg, lat);
      model(tab[k].x, tab[k].y, eang, emag);
      chk($sformatf("latency[%0d]", k), lat, 17, 0);
      chk_ang($sformatf("angle_ideal[%0d]", k), ang, tab[k].ang, tab[k].atol);
      chk($sformatf("mag_ideal[%0d]", k), mg, tab[k].mag, tab[k].mtol);
      chk_ang($sformatf("angle_model[%0d]", k), ang, eang, 0);
      chk($sformatf("mag_model[%0d]", k), mg, emag, 0);
    end

    run_op(16'sd11585, 16'sd11585, ang, mg, lat);
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0, 0);
    chk("busy_after_done", busy, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk_ang("angle_hold", angle_out, ang, 0);
    chk("mag_hold", mag_out, mg, 0);

    // start pulsed at cycle 5 of an operation must be ignored
    @(negedge clk);
    x_in = 16'sd16384; y_in = 16'sd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; first = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 4) begin start = 1'b1; x_in = -16'sd9000; y_in = 16'sd2000; end
      if (c == 5) start = 1'b0;
      if (done) begin
        nd++;
        if (first < 0) begin first = c; ang = angle_out; mg = mag_out; end
      end
    end
    model(16'sd16384, 16'sd0, eang, emag);
    chk("ignore_done_count", nd, 1, 0);
    chk("ignore_done_cycle", first, 17, 0);
    chk_ang("ignore_angle", ang, eang, 0);
    chk("ignore_mag", mg, emag, 0);

    // reset asserted at cycle 8 aborts without a done pulse
    @(negedge clk);
    x_in = -16'sd16384; y_in = -16'sd16384; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0, 0);
    chk("abort_angle", angle_out, 0, 0);
    chk("abort_mag", mag_out, 0, 0);
    nd = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0, 0);
    run_op(16'sd0, 16'sd16384, ang, mg, lat);
    model(16'sd0, 16'sd16384, eang, emag);
    chk("fresh_latency", lat, 17, 0);
    chk_ang("fresh_angle", ang, eang, 0);
    chk("fresh_mag", mg, emag, 0);

    // start held across done is accepted on the done cycle, giving back-to-back results
    @(negedge clk);
    x_in = 16'sd11585; y_in = -16'sd5000; start = 1'b1;
    @(posedge clk); #1;
    x_in = -16'sd7000; y_in = 16'sd12000;
    first = -1; second = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 18) begin
        start = 1'b0;
        chk("b2b_accept_busy", busy, 1, 0);
      end
      if (done && first < 0) begin first = c; ang = angle_out; mg = mag_out; end
      else if (done && second < 0) begin second = c; ang2 = angle_out; mg2 = mag_out; end
    end
    start = 1'b0;
    model(16'sd11585, -16'sd5000, eang, emag);
    model(-16'sd7000, 16'sd12000, eang2, emag2);
    chk("b2b_first_cycle", first, 17, 0);
    chk("b2b_second_cycle", second, 35, 0);
    chk_ang("b2b_angle_a", ang, eang, 0);
    chk("b2b_mag_a", mg, emag, 0);
    chk_ang("b2b_angle_b", ang2, eang2, 0);
    chk("b2b_mag_b", mg2, emag2, 0);

    for (int k = 0; k < 40; k++) begin
      logic signed [15:0] rx, ry;
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (k == 0) begin rx = -16'sd32768; ry = -16'sd32768; end
      if (k == 1) begin rx = 16'sd32767; ry = -16'sd32768; end
      run_op(rx, ry, ang, mg, lat);
      model(rx, ry, eang, emag);
      chk($sformatf("rand_latency[%0d]", k), lat, 17, 0);
      chk_ang($sformatf("rand_angle[%0d] x=%0d y=%0d", k, rx, ry), ang, eang, 0);
      chk($sformatf("rand_mag[%0d] x=%0d y=%0d", k, rx, ry), mg, emag, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
